// File: rtl/tim_arbiter_if.sv
// Bus bundle between the tim arbiter and its two requesters plus the tim memory.
// slave: arbiter side. master: requesters and tim side (testbench / surrounding core).
interface tim_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  // Fetch port (read only)
  logic                  ireq_valid;
  logic [ADDR_WIDTH-1:0] ireq_addr;
  logic                  irsp_ready;
  logic [31:0]           irsp_rdata;
  // Load/store port
  logic                  dreq_valid;
  logic [ADDR_WIDTH-1:0] dreq_addr;
  logic [31:0]           dreq_wdata;
  logic [3:0]            dreq_wstrb;
  logic                  drsp_ready;
  logic [31:0]           drsp_rdata;
  // Shared tim request port
  logic                  tim_valid;
  logic                  tim_instr;
  logic [ADDR_WIDTH-1:0] tim_addr;
  logic [31:0]           tim_wdata;
  logic [3:0]            tim_wstrb;
  logic [31:0]           tim_rdata;
  logic                  tim_ready;

  modport slave (
    input  ireq_valid, ireq_addr,
    output irsp_ready, irsp_rdata,
    input  dreq_valid, dreq_addr, dreq_wdata, dreq_wstrb,
    output drsp_ready, drsp_rdata,
    output tim_valid, tim_instr, tim_addr, tim_wdata, tim_wstrb,
    input  tim_rdata, tim_ready
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  irsp_ready, irsp_rdata,
    output dreq_valid, dreq_addr, dreq_wdata, dreq_wstrb,
    input  drsp_ready, drsp_rdata,
    input  tim_valid, tim_instr, tim_addr, tim_wdata, tim_wstrb,
    output tim_rdata, tim_ready
  );
endinterface

// File: rtl/tim_arbiter.sv
// Two-port arbiter in front of the pipelined tim memory. Issues at most one request
// per cycle, holds one losing request per port, routes each response back to the
// port that issued it. Optional macro TIM_ARB_RR_EN: round-robin tie-break between
// two live requests; without it a tie always goes to the load/store port.
module tim_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input logic          clock,
  input logic          reset,  // synchronous, active-low
  tim_arbiter_if.slave bus
);

  typedef enum logic {PortI = 1'b0, PortD = 1'b1} port_e;

  // Pending (captured losing) requests
  logic                  pend_i_q, pend_i_d;
  logic [ADDR_WIDTH-1:0] pend_i_addr_q, pend_i_addr_d;
  logic                  pend_d_q, pend_d_d;
  logic [ADDR_WIDTH-1:0] pend_d_addr_q, pend_d_addr_d;
  logic [31:0]           pend_d_wdata_q, pend_d_wdata_d;
  logic [3:0]            pend_d_wstrb_q, pend_d_wstrb_d;

  // Request in flight inside tim
  logic  owner_v_q, owner_v_d;
  port_e owner_q, owner_d;

`ifdef TIM_ARB_RR_EN
  port_e rr_last_q, rr_last_d;
`endif

  logic  live_i, live_d;
  logic  grant_v;
  port_e grant_port;
  port_e tie_port;
  logic  rsp_v;

  // A live pulse is ignored while the same port already holds a pending entry.
  assign live_i = bus.ireq_valid & ~pend_i_q;
  assign live_d = bus.dreq_valid & ~pend_d_q;

`ifdef TIM_ARB_RR_EN
  assign tie_port = (rr_last_q == PortD) ? PortI : PortD;
`else
  assign tie_port = PortD;
`endif

  // Grant selection: pending beats live, d beats i among pendings, tie rule for live pairs.
  always_comb begin
    grant_v    = 1'b0;
    grant_port = PortD;
    if (pend_d_q) begin
      grant_v    = 1'b1;
      grant_port = PortD;
    end else if (pend_i_q) begin
      grant_v    = 1'b1;
      grant_port = PortI;
    end else if (live_i && live_d) begin
      grant_v    = 1'b1;
      grant_port = tie_port;
    end else if (live_d) begin
      grant_v    = 1'b1;
      grant_port = PortD;
    end else if (live_i) begin
      grant_v    = 1'b1;
      grant_port = PortI;
    end
    if (!reset) begin
      grant_v = 1'b0;
    end
  end

  // Drive the granted request onto tim; fetches always carry zero data and strobes.
  always_comb begin
    bus.tim_valid = grant_v;
    bus.tim_instr = 1'b0;
    bus.tim_addr  = '0;
    bus.tim_wdata = '0;
    bus.tim_wstrb = '0;
    if (grant_v) begin
      if (grant_port == PortI) begin
        bus.tim_instr = 1'b1;
        bus.tim_addr  = pend_i_q ? pend_i_addr_q : bus.ireq_addr;
      end else begin
        bus.tim_addr  = pend_d_q ? pend_d_addr_q  : bus.dreq_addr;
        bus.tim_wdata = pend_d_q ? pend_d_wdata_q : bus.dreq_wdata;
        bus.tim_wstrb = pend_d_q ? pend_d_wstrb_q : bus.dreq_wstrb;
      end
    end
  end

  // Route a tim response to the owner recorded at issue; stray responses are dropped.
  always_comb begin
    rsp_v          = reset & bus.tim_ready & owner_v_q;
    bus.irsp_ready = rsp_v & (owner_q == PortI);
    bus.drsp_ready = rsp_v & (owner_q == PortD);
    bus.irsp_rdata = bus.irsp_ready ? bus.tim_rdata : 32'h0;
    bus.drsp_rdata = bus.drsp_ready ? bus.tim_rdata : 32'h0;
  end

  // Next state: capture live losers, retire granted pendings, record the new owner.
  always_comb begin
    pend_i_d       = pend_i_q;
    pend_i_addr_d  = pend_i_addr_q;
    pend_d_d       = pend_d_q;
    pend_d_addr_d  = pend_d_addr_q;
    pend_d_wdata_d = pend_d_wdata_q;
    pend_d_wstrb_d = pend_d_wstrb_q;
    owner_v_d      = grant_v;
    owner_d        = grant_v ? grant_port : owner_q;

    if (grant_v && grant_port == PortI && pend_i_q) begin
      pend_i_d = 1'b0;
    end
    if (live_i && !(grant_v && grant_port == PortI)) begin
      pend_i_d      = 1'b1;
      pend_i_addr_d = bus.ireq_addr;
    end

    if (grant_v && grant_port == PortD && pend_d_q) begin
      pend_d_d = 1'b0;
    end
    if (live_d && !(grant_v && grant_port == PortD)) begin
      pend_d_d       = 1'b1;
      pend_d_addr_d  = bus.dreq_addr;
      pend_d_wdata_d = bus.dreq_wdata;
      pend_d_wstrb_d = bus.dreq_wstrb;
    end
  end

`ifdef TIM_ARB_RR_EN
  // Tie-break history: remember the port of every grant.
  always_comb begin
    rr_last_d = rr_last_q;
    if (grant_v) begin
      rr_last_d = grant_port;
    end
  end

  // Reset to "d granted last" so i wins the first tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_last_q <= PortD;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  // State registers; reset discards pending and in-flight requests.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_i_q       <= 1'b0;
      pend_i_addr_q  <= '0;
      pend_d_q       <= 1'b0;
      pend_d_addr_q  <= '0;
      pend_d_wdata_q <= '0;
      pend_d_wstrb_q <= '0;
      owner_v_q      <= 1'b0;
      owner_q        <= PortI;
    end else begin
      pend_i_q       <= pend_i_d;
      pend_i_addr_q  <= pend_i_addr_d;
      pend_d_q       <= pend_d_d;
      pend_d_addr_q  <= pend_d_addr_d;
      pend_d_wdata_q <= pend_d_wdata_d;
      pend_d_wstrb_q <= pend_d_wstrb_d;
      owner_v_q      <= owner_v_d;
      owner_q        <= owner_d;
    end
  end

endmodule
